wb_hist_regs: RTL and testbench
===============================

Name: wb_hist_regs

Overview:
Parametrised post-writeback pipeline register chain; successor to the single-stage wb output register.
- Holds the last DEPTH register-file write records (data, address, write-enable) in a shift chain.
- Presents the oldest record as the delayed write port.
- Provides NUM_RD combinational forwarding lookups that return the youngest matching record, so decode/execute can bypass late-retiring writes.
- Sits between the wb stage and the regfile write port / forwarding mux.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width (x0 = address 0)
DEPTH, 2, number of history stages, >= 1
NUM_RD, 2, number of forwarding query ports, >= 1

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset
stall_i  in  1  hold all stages
flush_i  in  1  invalidate all stages
reg_wdata_i  in  DATA_W  write data from wb
reg_we_i  in  1  write enable from wb
reg_waddr_i  in  ADDR_W  write address from wb
reg_wdata_o  out  DATA_W  oldest stage (DEPTH-1) data
reg_we_o  out  1  oldest stage write enable
reg_waddr_o  out  ADDR_W  oldest stage address
rd_addr_i  in  NUM_RD*ADDR_W  packed query addresses, port k at bits [k*ADDR_W +: ADDR_W]
fwd_hit_o  out  NUM_RD  per-port hit flag
fwd_data_o  out  NUM_RD*DATA_W  per-port forwarded data, packed like rd_addr_i

Behaviour:
- Reset (rst low, asynchronous): every stage data = 0, we = 0, addr = 0. Hence reg_wdata_o = 0, reg_we_o = 0, reg_waddr_o = 0, fwd_hit_o = 0 and fwd_data_o = 0 while in reset and after release until new writes arrive.
- Stage 0 captures the inputs. Stage i captures stage i-1. Outputs are driven directly from stage DEPTH-1, so latency from input to output is DEPTH cycles. DEPTH = 1 is equivalent to the legacy single register.
- Input qualification: the captured we = reg_we_i AND (reg_waddr_i != 0). A write to x0 is never recorded as valid. Data and address are still captured.
- Priority per edge is reset > flush > stall > shift.
  - flush_i = 1: all we bits cleared. Data and addr are don't-care but held. The input is dropped even if stall_i = 1.
  - stall_i = 1 (no flush): every stage holds, including the outputs. The input is dropped; the upstream stage is responsible for holding it.
  - Otherwise: shift by one.
- Forwarding (combinational, per port k):
  - Search stages 0..DEPTH-1 for we = 1 and addr == rd_addr_k.
  - The lowest-index (youngest) match wins.
  - fwd_hit_o[k] = 1 and fwd_data_o[k] = that stage's data.
  - No match, or rd_addr_k = 0: hit = 0 and data = 0.
  - The incoming reg_*_i is not searched; the wb stage forwards its own value.
- Simultaneous events:
  - Query during stall sees the held contents.
  - Query in the cycle flush_i is asserted still sees the pre-flush contents, since flush takes effect at the edge.
- Reset mid-operation clears all stages immediately, without waiting for a clock edge.

Decomposition:
- Shared defines: RegBus, RegAddrBus, ZeroWord, ZeroReg, WriteEnable/WriteDisable (existing defines file). Defaults of DATA_W/ADDR_W tie to these widths.
- Sub-module wb_hist_stage: one stage register with rst/stall/flush handling. Instantiated DEPTH times via generate.
- Forwarding priority search lives in the top level as a generate loop over NUM_RD.

Test Plan:
- Reset: hold rst=0 for 3 cycles with we_i=1, addr=5, data=0xAA. Required: all outputs 0 and fwd_hit_o=0. Release rst; with DEPTH=2, the output shows we=1, addr=5, data=0xAA exactly 2 edges later.
- Forward priority: write x7=0x11, then x7=0x22 on consecutive cycles; query rd_addr[0]=7. Required: hit=1, data=0x22 (youngest). Two cycles after input stops, data=0x22 from the last stage, then hit=0.
- x0 filter: we_i=1, addr=0, data=0xFFFF. Required: reg_we_o=0 at output time; query addr 0 gives hit=0, data=0.
- Stall: fill x3=0x33, x4=0x44; assert stall_i for 3 cycles while driving x9=0x99. Required: outputs and forwarding unchanged for all 3 cycles, and x9 never appears.
- Flush with stall: stages hold x3 and x4; assert flush_i=1 and stall_i=1 together. Required: the next cycle has reg_we_o=0 and all hits 0; the concurrent input is dropped.
- Async reset mid-stream: during shifting, drop rst between edges. Required: outputs go to 0 before the next rising clk edge.

Source files
------------

// File: rtl/wb_hist_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_hist_regs_pkg
// Purpose  : Shared register-file widths, constants and write qualification.
// Revision : 1.0 - initial release
// ============================================================================
package wb_hist_regs_pkg;

    localparam int c_reg_bus_w  = 32;
    localparam int c_reg_addr_w = 5;

    localparam logic [c_reg_bus_w-1:0]  c_zero_word     = '0;
    localparam logic [c_reg_addr_w-1:0] c_zero_reg      = '0;
    localparam logic                    c_write_enable  = 1'b1;
    localparam logic                    c_write_disable = 1'b0;

    // x0 is hardwired to zero, so a write to it must never look valid downstream.
    function automatic logic qualify_we(input logic we, input logic addr_nonzero);
        return (we && addr_nonzero) ? c_write_enable : c_write_disable;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_hist_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_hist_regs_if
// Purpose  : Bus bundle between the wb stage, the history chain and consumers.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_hist_regs_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) ();

    logic                     stall_i;
    logic                     flush_i;
    logic [DATA_W-1:0]        reg_wdata_i;
    logic                     reg_we_i;
    logic [ADDR_W-1:0]        reg_waddr_i;
    logic [DATA_W-1:0]        reg_wdata_o;
    logic                     reg_we_o;
    logic [ADDR_W-1:0]        reg_waddr_o;
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD-1:0]        fwd_hit_o;
    logic [NUM_RD*DATA_W-1:0] fwd_data_o;

    modport master (
        output stall_i, flush_i, reg_wdata_i, reg_we_i, reg_waddr_i, rd_addr_i,
        input  reg_wdata_o, reg_we_o, reg_waddr_o, fwd_hit_o, fwd_data_o
    );

    modport slave (
        input  stall_i, flush_i, reg_wdata_i, reg_we_i, reg_waddr_i, rd_addr_i,
        output reg_wdata_o, reg_we_o, reg_waddr_o, fwd_hit_o, fwd_data_o
    );

endinterface
`default_nettype wire

// File: rtl/wb_hist_regs_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_hist_stage
// Purpose  : One write-record history register with flush/stall control.
// Revision : 1.0 - initial release
// ============================================================================
module wb_hist_stage
    import wb_hist_regs_pkg::*;
#(
    parameter int DATA_W = c_reg_bus_w,
    parameter int ADDR_W = c_reg_addr_w
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_stall,
    input  wire logic              i_flush,
    input  wire logic [DATA_W-1:0] i_data,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_addr,
    output logic      [DATA_W-1:0] o_data,
    output logic                   o_we,
    output logic      [ADDR_W-1:0] o_addr
);

    logic [DATA_W-1:0] r_data;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;

    // Flush only kills the valid bit; data/addr keep their last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_we   <= c_write_disable;
            r_addr <= '0;
        end else if (i_flush) begin
            r_we   <= c_write_disable;
        end else if (!i_stall) begin
            r_data <= i_data;
            r_we   <= i_we;
            r_addr <= i_addr;
        end
    end

    assign o_data = r_data;
    assign o_we   = r_we;
    assign o_addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/wb_hist_regs.sv
`default_nettype none
// ============================================================================
// Module   : wb_hist_regs
// Purpose  : DEPTH-stage post-writeback history chain with youngest-match
//            forwarding lookups on NUM_RD query ports.
// Revision : 1.0 - initial release
// ============================================================================
module wb_hist_regs
    import wb_hist_regs_pkg::*;
#(
    parameter int DATA_W = c_reg_bus_w,
    parameter int ADDR_W = c_reg_addr_w,
    parameter int DEPTH  = 2,
    parameter int NUM_RD = 2
) (
    input  wire logic     clk,
    input  wire logic     rst,
    wb_hist_regs_if.slave bus
);

    logic [DATA_W-1:0] w_st_data [DEPTH];
    logic              w_st_we   [DEPTH];
    logic [ADDR_W-1:0] w_st_addr [DEPTH];

    wire  [NUM_RD-1:0]        w_fwd_hit;
    wire  [NUM_RD*DATA_W-1:0] w_fwd_data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [DATA_W-1:0] w_d_data;
        logic              w_d_we;
        logic [ADDR_W-1:0] w_d_addr;

        if (i == 0) begin : g_head
            assign w_d_data = bus.reg_wdata_i;
            assign w_d_we   = qualify_we(bus.reg_we_i, bus.reg_waddr_i != '0);
            assign w_d_addr = bus.reg_waddr_i;
        end else begin : g_tail
            assign w_d_data = w_st_data[i-1];
            assign w_d_we   = w_st_we[i-1];
            assign w_d_addr = w_st_addr[i-1];
        end

        wb_hist_stage #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_stall (bus.stall_i),
            .i_flush (bus.flush_i),
            .i_data  (w_d_data),
            .i_we    (w_d_we),
            .i_addr  (w_d_addr),
            .o_data  (w_st_data[i]),
            .o_we    (w_st_we[i]),
            .o_addr  (w_st_addr[i])
        );
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_fwd
        logic [ADDR_W-1:0] w_raddr;
        logic              w_hit;
        logic [DATA_W-1:0] w_data;

        assign w_raddr = bus.rd_addr_i[k*ADDR_W +: ADDR_W];

        // Scan oldest to youngest so the youngest match overwrites the rest.
        always_comb begin
            w_hit  = 1'b0;
            w_data = c_zero_word[DATA_W-1:0];
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (w_st_we[i] && (w_st_addr[i] == w_raddr) && (w_raddr != '0)) begin
                    w_hit  = 1'b1;
                    w_data = w_st_data[i];
                end
            end
        end

        assign w_fwd_hit[k]                   = w_hit;
        assign w_fwd_data[k*DATA_W +: DATA_W] = w_data;
    end

    assign bus.reg_wdata_o = w_st_data[DEPTH-1];
    assign bus.reg_we_o    = w_st_we[DEPTH-1];
    assign bus.reg_waddr_o = w_st_addr[DEPTH-1];
    assign bus.fwd_hit_o   = w_fwd_hit;
    assign bus.fwd_data_o  = w_fwd_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_hist_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_hist_regs
// Purpose  : Directed-vector scoreboard bench for wb_hist_regs (DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_hist_regs;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [4:0]  q0;
        logic [4:0]  q1;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [1:0]  e_hit;
        logic [31:0] e_f0;
        logic [31:0] e_f1;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs[$];
    vec_t sb[$];

    wb_hist_regs_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

    wb_hist_regs #(
        .DATA_W (32),
        .ADDR_W (5),
        .DEPTH  (2),
        .NUM_RD (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic st, input logic fl,
        input logic we, input logic [4:0] a, input logic [31:0] d,
        input logic [4:0] q0, input logic [4:0] q1,
        input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
        input logic [1:0] eh, input logic [31:0] ef0, input logic [31:0] ef1);
        vec_t v;
        v.rst = r;  v.stall = st; v.flush = fl; v.we = we; v.addr = a; v.data = d;
        v.q0 = q0;  v.q1 = q1;
        v.e_we = ewe; v.e_addr = ea; v.e_data = ed; v.e_hit = eh; v.e_f0 = ef0; v.e_f1 = ef1;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL row %0d %s: got 0x%0h expected 0x%0h", row, nm, act, exp);
        end
    endtask

    // Monitor: every negedge with a pending expectation is compared.
    initial begin
        int row;
        vec_t e;
        row = 0;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("reg_we_o",    row, 64'(bus.reg_we_o),          64'(e.e_we));
                chk("reg_waddr_o", row, 64'(bus.reg_waddr_o),       64'(e.e_addr));
                chk("reg_wdata_o", row, 64'(bus.reg_wdata_o),       64'(e.e_data));
                chk("fwd_hit_o",   row, 64'(bus.fwd_hit_o),         64'(e.e_hit));
                chk("fwd_data0",   row, 64'(bus.fwd_data_o[31:0]),  64'(e.e_f0));
                chk("fwd_data1",   row, 64'(bus.fwd_data_o[63:32]), 64'(e.e_f1));
                row++;
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.stall_i = 1'b0; bus.flush_i = 1'b0;
        bus.reg_we_i = 1'b0; bus.reg_waddr_i = '0; bus.reg_wdata_i = '0;
        bus.rd_addr_i = '0;

        //               rst st fl we addr data      q0 q1   ewe ea  edata    hit    f0       f1
        // reset held with a live write on the inputs
        vecs.push_back(mk(0, 0, 0, 1, 5,  32'hAA,   5, 0,   0,  0,  32'h0,   2'b00, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 5,  32'hAA,   5, 0,   0,  0,  32'h0,   2'b00, 32'h0,  32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 5,  32'hAA,   5, 0,   0,  0,  32'h0,   2'b00, 32'h0,  32'h0));
        // release: x5 appears two edges later
        vecs.push_back(mk(1, 0, 0, 1, 5,  32'hAA,   5, 0,   0,  0,  32'h0,   2'b00, 32'h0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,    5, 0,   0,  0,  32'h0,   2'b01, 32'hAA, 32'h0));
        // forwarding priority on x7
        vecs.push_back(mk(1, 0, 0, 1, 7,  32'h11,   5, 7,   1,  5,  32'hAA,  2'b01, 32'hAA, 32'h0));
        vecs.push_back(mk(1, 0, 0, 1, 7,  32'h22,   7, 5,   0,  0,  32'h0,   2'b01, 32'h11, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,    7, 7,   1,  7,  32'h11,  2'b11, 32'h22, 32'h22));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,    7, 0,   1,  7,  32'h22,  2'b01, 32'h22, 32'h0));
        // x0 filter
        vecs.push_back(mk(1, 0, 0, 1, 0,  32'hFFFF, 7, 0,   0,  0,  32'h0,   2'b00, 32'h0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,    0, 0,   0,  0,  32'h0,   2'b00, 32'h0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,    0, 0,   0,  0,  32'hFFFF,2'b00, 32'h0,  32'h0));
        // fill x3, x4 then stall three cycles with x9 on the inputs
        vecs.push_back(mk(1, 0, 0, 1, 3,  32'h33,   3, 4,   0,  0,  32'h0,   2'b00, 32'h0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 1, 4,  32'h44,   3, 4,   0,  0,  32'h0,   2'b01, 32'h33, 32'h0));
        vecs.push_back(mk(1, 1, 0, 1, 9,  32'h99,   3, 4,   1,  3,  32'h33,  2'b11, 32'h33, 32'h44));
        vecs.push_back(mk(1, 1, 0, 1, 9,  32'h99,   3, 4,   1,  3,  32'h33,  2'b11, 32'h33, 32'h44));
        vecs.push_back(mk(1, 1, 0, 1, 9,  32'h99,   9, 4,   1,  3,  32'h33,  2'b10, 32'h0,  32'h44));
        // flush together with stall: query still sees pre-flush contents
        vecs.push_back(mk(1, 1, 1, 1, 9,  32'h99,   3, 4,   1,  3,  32'h33,  2'b11, 32'h33, 32'h44));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,    3, 4,   0,  3,  32'h33,  2'b00, 32'h0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,    4, 9,   0,  4,  32'h44,  2'b00, 32'h0,  32'h0));
        // asynchronous reset between edges while shifting
        vecs.push_back(mk(1, 0, 0, 1, 12, 32'hC,   12, 0,   0,  0,  32'h0,   2'b00, 32'h0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 1, 13, 32'hD,   12, 13,  0,  0,  32'h0,   2'b01, 32'hC,  32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 14, 32'hE,   12, 13,  0,  0,  32'h0,   2'b00, 32'h0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,   12, 13,  0,  0,  32'h0,   2'b00, 32'h0,  32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0,  32'h0,   12, 13,  0,  0,  32'h0,   2'b00, 32'h0,  32'h0));

        foreach (vecs[n]) begin
            @(posedge clk);
            #1;
            rst             = vecs[n].rst;
            bus.stall_i     = vecs[n].stall;
            bus.flush_i     = vecs[n].flush;
            bus.reg_we_i    = vecs[n].we;
            bus.reg_waddr_i = vecs[n].addr;
            bus.reg_wdata_i = vecs[n].data;
            bus.rd_addr_i   = {vecs[n].q1, vecs[n].q0};
            sb.push_back(vecs[n]);
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
